dpram_wr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the write port (clk1 domain) of the dual-port CDC RAM.

---
 rtl/dpram_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_dpram_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_wr_arbiter.sv
// dpram_wr_arbiter
//   Round-robin arbiter and write sequencer for the clk1 write port of the
//   dual-port CDC RAM. One requester at a time is granted the shared
//   addr_1/data_1/wr_en port. Each write is held for HOLD_CYC cycles and is
//   followed by GAP_CYC idle cycles, so the RAM's handshake CDC can settle.
//
// Ports
//   clk1      in   RAM write-side clock, rising edge
//   rst       in   asynchronous, active-high reset
//   req       in   [NUM_REQ]          per-requester write request (level)
//   req_addr  in   [NUM_REQ*ADDR_W]   requester i address at [i*ADDR_W +: ADDR_W]
//   req_data  in   [NUM_REQ*DATA_W]   requester i data at [i*DATA_W +: DATA_W]
//   gnt       out  [NUM_REQ]          one-hot, one-cycle grant pulse
//   wr_en     out  RAM write enable
//   addr_1    out  [ADDR_W]           RAM write address
//   data_1    out  [DATA_W]           RAM write data
//   busy      out  high whenever the sequencer is not idle
module dpram_wr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned GAP_CYC  = 3
) (
  input  logic                      clk1,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         addr_1,
  output logic [DATA_W-1:0]         data_1,
  output logic                      busy
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W   = PTR_W + 1;
  localparam int unsigned CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0] SUM_WRAP = SUM_W'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                busy_nxt;

  logic [2*NUM_REQ-1:0] req_rot;
  logic [PTR_W-1:0]     win_off;
  logic [SUM_W-1:0]     win_sum;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_vld;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  assign req_rot = {req, req} >> ptr;

  // Winner search: offset from ptr, then wrap back into 0..NUM_REQ-1.
  always_comb begin
    win_off = '0;
    win_vld = |req;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = PTR_W'(k);
    end
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    win_idx = (win_sum >= SUM_WRAP) ? PTR_W'(win_sum - SUM_WRAP) : PTR_W'(win_sum);
  end

  // State and output registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      gnt    <= '0;
      wr_en  <= 1'b0;
      addr_1 <= '0;
      data_1 <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      wr_en  <= wr_en_nxt;
      addr_1 <= addr_nxt;
      data_1 <= data_nxt;
      busy   <= busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    wr_en_nxt = 1'b0;
    addr_nxt  = addr_1;
    data_nxt  = data_1;

    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = WRITE;
          cnt_nxt   = HOLD_LD;
          gnt_nxt   = NUM_REQ'(1) << win_idx;
          wr_en_nxt = 1'b1;
          addr_nxt  = req_addr[win_idx*ADDR_W +: ADDR_W];
          data_nxt  = req_data[win_idx*DATA_W +: DATA_W];
          ptr_nxt   = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
        end
      end
      WRITE: begin
        if (cnt == '0) begin
          // Last hold cycle: drop wr_en and settle (or skip straight to idle).
          if (GAP_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          wr_en_nxt = 1'b1;
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// tb_dpram_wr_arbiter
//   Self-checking bench for dpram_wr_arbiter: a cycle-vector table, hand-written
//   corner sequences, and randomized traffic checked against a timeline model.
module tb_dpram_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int          NI = 4;
  localparam int          HOLD = 2;
  localparam int          GAP  = 3;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            wr_en, busy;
  logic [AW-1:0]   addr_1;
  logic [DW-1:0]   data_1;

  logic [N-1:0]    req_b = '0;
  logic [N*AW-1:0] req_addr_b = '0;
  logic [N*DW-1:0] req_data_b = '0;
  logic [N-1:0]    gnt_b;
  logic            wr_en_b, busy_b;
  logic [AW-1:0]   addr_1_b;
  logic [DW-1:0]   data_1_b;

  dpram_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .HOLD_CYC(2), .GAP_CYC(3)) dut (
    .clk1(clk1), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_en(wr_en), .addr_1(addr_1), .data_1(data_1), .busy(busy)
  );

  dpram_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .HOLD_CYC(1), .GAP_CYC(0)) dut_b (
    .clk1(clk1), .rst(rst), .req(req_b), .req_addr(req_addr_b), .req_data(req_data_b),
    .gnt(gnt_b), .wr_en(wr_en_b), .addr_1(addr_1_b), .data_1(data_1_b), .busy(busy_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus plus the outputs expected right after that edge.
  typedef struct {
    logic          rst;
    logic [3:0]    req;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [3:0]    gnt;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic [3:0] g, input logic w,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.gnt = g; v.wr = w; v.addr = ea; v.data = ed; v.busy = b;
    return v;
  endfunction

  task automatic reset_pulse();
    @(negedge clk1);
    rst = 1'b1; req = '0; req_b = '0;
    @(negedge clk1);
    rst = 1'b0;
  endtask

  // Timeline reference model: a grant at edge g owns the port for edges
  // g..g+HOLD-1 (wr_en), stays busy through g+HOLD+GAP-1, and the next grant
  // can be taken no earlier than edge g+HOLD+GAP+1.
  int            m_n, m_g, m_w, m_ptr, m_next;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  e_gnt;
  logic          e_wr, e_busy;

  task automatic model_reset();
    m_n = 0; m_g = -1000; m_w = 0; m_ptr = 0; m_next = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    if (m_n >= m_next && req != '0) begin
      for (int k = 0; k < NI; k++) begin
        int idx;
        idx = (m_ptr + k) % NI;
        if (req[idx]) begin
          m_w = idx;
          break;
        end
      end
      m_g    = m_n;
      m_ptr  = (m_w + 1) % NI;
      m_addr = req_addr[m_w*AW +: AW];
      m_data = req_data[m_w*DW +: DW];
      m_next = m_n + HOLD + GAP + 1;
    end
    e_gnt  = (m_n == m_g) ? N'(1 << m_w) : '0;
    e_wr   = (m_n >= m_g) && (m_n < m_g + HOLD);
    e_busy = (m_n >= m_g) && (m_n < m_g + HOLD + GAP);
    m_n++;
  endtask

  logic [N-1:0] pend;
  logic [3:0]   exp_g;
  int           w;

  initial begin
    // Test 1: single requester; test 2: simultaneous after reset; test 5: GAP pulse ignored.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 10'h005, 8'hA5, 0, 0, 4'b0001, 1, 10'h005, 8'hA5, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h005, 8'hA5, 0, 0, 4'b0000, 1, 10'h005, 8'hA5, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h005, 8'hA5, 0, 0, 4'b0000, 0, 10'h005, 8'hA5, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h005, 8'hA5, 0, 0, 4'b0000, 0, 10'h005, 8'hA5, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h005, 8'hA5, 0, 0, 4'b0000, 0, 10'h005, 8'hA5, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h005, 8'hA5, 0, 0, 4'b0000, 0, 10'h005, 8'hA5, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0001, 1, 10'h011, 8'h11, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 1, 10'h011, 8'h11, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h011, 8'h11, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h011, 8'h11, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h011, 8'h11, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h011, 8'h11, 0));
    tbl.push_back(mk(0, 4'b0010, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0010, 1, 10'h022, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 1, 10'h022, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h022, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h022, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h022, 8'h22, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 8'h11, 10'h022, 8'h22, 4'b0000, 0, 10'h022, 8'h22, 0));
    tbl.push_back(mk(0, 4'b0001, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0001, 1, 10'h03C, 8'h5A, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 1, 10'h03C, 8'h5A, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 1));
    tbl.push_back(mk(0, 4'b0010, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 1));
    tbl.push_back(mk(0, 4'b0000, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 0));
    tbl.push_back(mk(0, 4'b0000, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 0));
    tbl.push_back(mk(0, 4'b0000, 10'h03C, 8'h5A, 10'h3FF, 8'hEE, 4'b0000, 0, 10'h03C, 8'h5A, 0));

    foreach (tbl[i]) begin
      @(negedge clk1);
      rst = tbl[i].rst;
      req = tbl[i].req;
      req_addr = '0;
      req_data = '0;
      req_addr[0 +: AW]  = tbl[i].a0;
      req_addr[AW +: AW] = tbl[i].a1;
      req_data[0 +: DW]  = tbl[i].d0;
      req_data[DW +: DW] = tbl[i].d1;
      @(posedge clk1);
      #1;
      check($sformatf("vec%0d {gnt,wr,addr,data,busy}", i),
            {gnt, wr_en, addr_1, data_1, busy},
            {tbl[i].gnt, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].busy});
    end

    // Test 3: all requesters held -> round-robin 0,1,2,3,0 every 6 cycles.
    reset_pulse();
    for (int i = 0; i < NI; i++) begin
      req_addr[i*AW +: AW] = AW'(32'h100 + i);
      req_data[i*DW +: DW] = DW'(32'hC0 + i);
    end
    req = '1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk1);
      #1;
      exp_g = (k % 6 == 0) ? 4'(1 << ((k / 6) % 4)) : 4'b0000;
      check($sformatf("rr_gnt_k%0d", k), 64'(gnt), 64'(exp_g));
      if (k % 6 == 0) begin
        w = (k / 6) % 4;
        check($sformatf("rr_addr_k%0d", k), 64'(addr_1), 64'(32'h100 + w));
        check($sformatf("rr_data_k%0d", k), 64'(data_1), 64'(32'hC0 + w));
      end
    end
    req = '0;

    // Test 4: reset mid-WRITE clears outputs without a clock edge.
    reset_pulse();
    req_addr[0 +: AW] = 10'h2AA;
    req_data[0 +: DW] = 8'h33;
    req = 4'b0001;
    @(posedge clk1);
    #1;
    check("midrst_pre_wr", 64'(wr_en), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async_clear", {gnt, wr_en, busy, addr_1, data_1}, 64'(0));
    @(negedge clk1);
    rst = 1'b0;
    req = 4'b0100;
    req_addr[2*AW +: AW] = 10'h155;
    req_data[2*DW +: DW] = 8'h77;
    @(posedge clk1);
    #1;
    check("midrst_regrant", {gnt, wr_en, addr_1, data_1, busy}, {4'b0100, 1'b1, 10'h155, 8'h77, 1'b1});
    req = '0;

    // Test 6: HOLD_CYC=1, GAP_CYC=0 -> grant and write every other cycle.
    reset_pulse();
    req_addr_b[0 +: AW] = 10'h00F;
    req_data_b[0 +: DW] = 8'h99;
    req_b = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk1);
      #1;
      check($sformatf("fast_k%0d {gnt,wr,busy}", k), {gnt_b, wr_en_b, busy_b},
            (k % 2 == 0) ? {4'b0001, 1'b1, 1'b1} : 6'b0);
    end
    check("fast_addr_data", {addr_1_b, data_1_b}, {10'h00F, 8'h99});
    req_b = '0;

    // Randomized traffic with handshake-obeying requesters versus the model.
    reset_pulse();
    model_reset();
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (pend[i] && gnt[i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom);
            req_data[i*DW +: DW] = DW'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req = pend;
      @(posedge clk1);
      model_edge();
      #1;
      check($sformatf("rand_c%0d {gnt,wr,addr,data,busy}", c),
            {gnt, wr_en, addr_1, data_1, busy},
            {e_gnt, e_wr, m_addr, m_data, e_busy});
      @(negedge clk1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
